cla_share_arbiter: RTL
======================

# cla_share_arbiter

Round-robin arbiter and sequencer that shares one combinational 16-bit carry-lookahead adder among NREQ requesters. Each requester posts an (a, b, cin) operation with a valid/ready handshake. The block grants one requester at a time and registers its operands onto the shared adder's inputs. It captures sum/cout into a response register tagged with the requester ID and holds it until the consumer accepts it. It also keeps a free-running count of completed operations. It sits between requester logic and the single shared CLA instance.

## Interface
- NREQ, 4, number of requesters (2..8); IDW = $clog2(NREQ)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester operation valid
- req_ready  out  NREQ  per-requester accept; at most one bit set
- req_a  in  NREQ*16  operand a; requester i uses bits [16i+15:16i]
- req_b  in  NREQ*16  operand b; same packing as req_a
- req_cin  in  NREQ  carry-in, one bit per requester
- cla_a  out  16  to shared adder, operand a
- cla_b  out  16  to shared adder, operand b
- cla_cin  out  1  to shared adder, carry-in
- cla_sum  in  16  from shared adder (combinational)
- cla_cout  in  1  from shared adder (combinational)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  IDW  index of the requester this response belongs to
- rsp_sum  out  16  captured sum
- rsp_cout  out  1  captured carry-out
- op_count  out  32  number of completed responses; wraps 2^32-1 -> 0

## Operation
- FSM states: IDLE, ISSUE, HOLD. Reset state is IDLE.
- Round-robin pointer `ptr` (IDW bits), reset 0.
- Grant:
  - grant = first i with req_valid[i], searching ptr, ptr+1, ... mod NREQ.
  - req_ready[grant] = 1 only when the state is IDLE and some req_valid is set. This path is combinational from req_valid.
- IDLE, on accept (req_valid[g] & req_ready[g]):
  - load op_a/op_b/op_cin from requester g; load id_q = g.
  - ptr <= (g+1) mod NREQ.
  - go to ISSUE.
- IDLE with no valid: stay in IDLE; ptr unchanged.
- ISSUE:
  - rsp_sum/rsp_cout <= cla_sum/cla_cout; rsp_id <= id_q; rsp_valid <= 1.
  - go to HOLD unconditionally.
- HOLD:
  - stay while !rsp_ready; all rsp_* outputs held stable.
  - on rsp_ready: rsp_valid <= 0, op_count <= op_count + 1, go to IDLE.
- cla_a/cla_b/cla_cin always drive op_a/op_b/op_cin from registers, so they are glitch-free and stable throughout ISSUE.
- Requester contract: once req_valid is raised, operands stay stable until req_ready is seen. Non-granted requesters keep waiting; they are not dropped.
- Arithmetic is done by the external adder only. The block applies no width extension, and rsp_cout is the adder's carry-out verbatim.

## Timing
- Reset values: req_ready 0, cla_a/cla_b 0, cla_cin 0, rsp_valid 0, rsp_id 0, rsp_sum 0, rsp_cout 0, op_count 0, ptr 0.
- While rst is high, req_ready = 0.
- Accept at edge T → ISSUE during T..T+1 → rsp_valid high after edge T+1.
- The earliest response handshake is at edge T+2. The next accept is earliest at edge T+3, giving a throughput of 1 operation per 3 cycles with rsp_ready tied high.
- rsp_valid is never asserted without a preceding accept, and it never drops without rsp_ready.
- Reset mid-operation (ISSUE or HOLD):
  - the in-flight result is discarded;
  - rsp_valid = 0 on the next cycle;
  - the FSM returns to IDLE;
  - op_count is not incremented.
- A reset on the same edge as a response handshake takes priority: op_count becomes 0.
- Simultaneous valids: exactly one grant per IDLE cycle, in rotating order. With all NREQ valids held high, grants follow ptr order with no starvation. Each requester is served within NREQ grants.
- op_count wraps silently from 32'hFFFF_FFFF to 0.

## Test plan
- Single op: requester 0, a=16'h1234, b=16'h4321, cin=0, rsp_ready=1 → rsp_valid after 2 edges; rsp_sum=16'h5555, rsp_cout=0, rsp_id=0, op_count=1.
- Carry out: requester 2, a=16'hFFFF, b=16'h0001, cin=1 → rsp_sum=16'h0001, rsp_cout=1, rsp_id=2.
- Fairness: all four valids held high with rsp_ready=1 → rsp_id sequence 0,1,2,3,0; one accept every 3 cycles.
- Backpressure: rsp_ready=0 for 10 cycles → rsp_* stable, no req_ready asserted; on rsp_ready=1 the response completes and the next grant follows.
- Reset in HOLD: assert rst for 1 cycle while rsp_valid=1 → rsp_valid=0, op_count=0, ptr=0; the next grant goes to the lowest-index valid.
- Pointer skip: only requesters 1 and 3 valid, ptr=2 → grant 3 first, then 1.

Source files
------------

// File: rtl/cla_share_arbiter_if.sv
// Bundle of the requester, shared-adder and response signals around
// cla_share_arbiter. The slave modport is the arbiter's view; the master
// modport is the surrounding logic (requesters, adder, consumer).
interface cla_share_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // requester side
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*16-1:0] req_a;
  logic [NREQ*16-1:0] req_b;
  logic [NREQ-1:0]    req_cin;

  // shared adder side
  logic [15:0]        cla_a;
  logic [15:0]        cla_b;
  logic               cla_cin;
  logic [15:0]        cla_sum;
  logic               cla_cout;

  // response side
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [15:0]        rsp_sum;
  logic               rsp_cout;
  logic [31:0]        op_count;

  modport slave (
    input  req_valid, req_a, req_b, req_cin, cla_sum, cla_cout, rsp_ready,
    output req_ready, cla_a, cla_b, cla_cin,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout, op_count
  );

  modport master (
    output req_valid, req_a, req_b, req_cin, cla_sum, cla_cout, rsp_ready,
    input  req_ready, cla_a, cla_b, cla_cin,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout, op_count
  );
endinterface

// File: rtl/cla_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one external 16-bit CLA among NREQ
// requesters. One operation is in flight at a time: accept (IDLE), let the
// registered operands settle through the adder (ISSUE), then hold the tagged
// result until the consumer takes it (HOLD).
module cla_share_arbiter #(
  parameter int NREQ = 4
) (
  input logic                clk,
  input logic                rst,
  cla_share_arbiter_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, HOLD = 2'd2} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, ptr_nxt, grant, idx, id_q;
  logic           any_valid, accept;
  logic [15:0]    a_arr [NREQ];
  logic [15:0]    b_arr [NREQ];
  logic [15:0]    op_a, op_b;
  logic           op_cin;
  logic           rsp_valid_q, rsp_cout_q;
  logic [IDW-1:0] rsp_id_q;
  logic [15:0]    rsp_sum_q;
  logic [31:0]    op_count_q;

  // Unpack the flat operand buses so the selected requester is a plain index.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      a_arr[k] = bus.req_a[k*16 +: 16];
      b_arr[k] = bus.req_b[k*16 +: 16];
    end
  end

  // Grant search: first valid requester starting at ptr, wrapping mod NREQ.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    grant     = '0;
    idx       = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!any_valid && bus.req_valid[idx]) begin
        grant     = idx;
        any_valid = 1'b1;
      end
    end
  end

  assign ptr_nxt = IDW'((int'(grant) + 1) % NREQ);
  assign accept  = (state == IDLE) && any_valid && !rst;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = HOLD;
      HOLD:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: one-hot ready to the granted requester, only in IDLE.
  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[grant] = 1'b1;
  end

  // Datapath: operand capture, pointer rotation, response and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      id_q        <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_cin      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      op_count_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_a   <= a_arr[grant];
            op_b   <= b_arr[grant];
            op_cin <= bus.req_cin[grant];
            id_q   <= grant;
            ptr    <= ptr_nxt;
          end
        end
        ISSUE: begin
          rsp_sum_q   <= bus.cla_sum;
          rsp_cout_q  <= bus.cla_cout;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
        end
        HOLD: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Adder inputs come straight from registers so they are stable in ISSUE.
  assign bus.cla_a     = op_a;
  assign bus.cla_b     = op_b;
  assign bus.cla_cin   = op_cin;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.op_count  = op_count_q;
endmodule
